irq_pending_ctrl: RTL and testbench

- Collects external interrupt lines, synchronises them, and edge- or level-qualifies each line into a pending register.
- Applies a software-written enable mask and presents the masked pending vector to the downstream priority encoder (Encoder_4, Encoder_8 or Encoder_16 by width).
- Runs a request/acknowledge/end-of-interrupt handshake with the core. The core returns the encoded ID it serviced, and this block clears that source.

---
 rtl/irq_pending_ctrl.sv | 164 ++++++++++++++++
 tb/tb_irq_pending_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/irq_pending_ctrl.sv
// irq_pending_ctrl
// Synchronises raw interrupt lines, qualifies each as edge- or level-sensitive
// into a pending register, masks it for the downstream priority encoder, and
// runs the request / acknowledge / end-of-interrupt handshake with the core.
// A single handler may be in service at a time; no nesting.

module irq_pending_ctrl #(
    parameter int unsigned      N_IRQ    = 8,              // 4, 8 or 16
    parameter int unsigned      ID_W     = 3,              // log2(N_IRQ)
    parameter logic [N_IRQ-1:0] EDGE_SEL = {N_IRQ{1'b1}}   // 1 = edge, 0 = level
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic [N_IRQ-1:0] irq_i,
    input  logic             mask_we_i,
    input  logic [N_IRQ-1:0] mask_wdata_i,
    output logic [N_IRQ-1:0] mask_o,
    output logic [N_IRQ-1:0] pending_o,
    output logic             irq_req_o,
    input  logic             ack_i,
    input  logic [ID_W-1:0]  ack_id_i,
    input  logic             eoi_i,
    output logic             active_o,
    output logic [ID_W-1:0]  active_id_o,
    output logic             ack_err_o
);

    // Handshake states
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_REQ    = 2'd1;
    localparam logic [1:0] ST_ACTIVE = 2'd2;

    logic [N_IRQ-1:0] r_s1;
    logic [N_IRQ-1:0] r_s2;
    logic [N_IRQ-1:0] r_s3;
    logic [N_IRQ-1:0] r_pending;
    logic [N_IRQ-1:0] r_mask;
    logic [1:0]       r_state;
    logic [ID_W-1:0]  r_active_id;
    logic             r_ack_err;

    logic [N_IRQ-1:0] w_pending_m;
    logic [N_IRQ-1:0] w_rise;
    logic [N_IRQ-1:0] w_ack_clr;
    logic [N_IRQ-1:0] w_pending_nxt;
    logic [1:0]       w_state_nxt;
    logic             w_ack_hit;
    logic             w_ack_ok;
    logic             w_ack_bad;

    assign w_pending_m = r_pending & r_mask;
    assign w_rise      = r_s2 & ~r_s3;

    // An ack is only meaningful while a request is outstanding; the ID must
    // point at a line that is both pending and enabled.
    assign w_ack_hit = w_pending_m[ack_id_i];
    assign w_ack_ok  = (r_state == ST_REQ) && ack_i &&  w_ack_hit;
    assign w_ack_bad = (r_state == ST_REQ) && ack_i && !w_ack_hit;

    assign mask_o      = r_mask;
    assign pending_o   = w_pending_m;
    assign irq_req_o   = (r_state == ST_REQ);
    assign active_o    = (r_state == ST_ACTIVE);
    assign active_id_o = r_active_id;
    assign ack_err_o   = r_ack_err;

    // One-hot clear vector for the line being accepted
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would infer a latch.
        w_ack_clr = '0;
        if (w_ack_ok) begin
            w_ack_clr = N_IRQ'(1) << ack_id_i;
        end
    end

    // Next pending value: edge lines latch rises (set beats clear), level lines follow s2
    always_comb begin
        w_pending_nxt = '0;
        for (int i = 0; i < N_IRQ; i++) begin
            if (EDGE_SEL[i]) begin
                w_pending_nxt[i] = w_rise[i] | (r_pending[i] & ~w_ack_clr[i]);
            end else begin
                w_pending_nxt[i] = r_s2[i];
            end
        end
    end

    // Handshake next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (|w_pending_m) begin
                    w_state_nxt = ST_REQ;
                end
            end
            ST_REQ: begin
                if (w_ack_ok) begin
                    w_state_nxt = ST_ACTIVE;
                end else if (w_pending_m == '0) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (eoi_i) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Two-flop synchroniser plus a third stage for edge detection
    always_ff @(posedge clk_i or negedge rst_ni) begin
        // NOTE: every register here, synchroniser included, has an explicit
        // reset value so a reset mid-handshake leaves no stale edge behind.
        if (!rst_ni) begin
            r_s1 <= '0;
            r_s2 <= '0;
            r_s3 <= '0;
        end else begin
            // NOTE: non-blocking assignments so each stage takes the previous
            // stage's old value and the chain really is three flops deep.
            r_s1 <= irq_i;
            r_s2 <= r_s1;
            r_s3 <= r_s2;
        end
    end

    // Pending register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_pending <= '0;
        end else begin
            r_pending <= w_pending_nxt;
        end
    end

    // Software enable mask
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_mask <= '0;
        end else if (mask_we_i) begin
            r_mask <= mask_wdata_i;
        end
    end

    // Handshake state, in-service ID and ack error pulse
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state     <= ST_IDLE;
            r_active_id <= '0;
            r_ack_err   <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_ack_err <= w_ack_bad;
            if (w_ack_ok) begin
                r_active_id <= ack_id_i;
            end
        end
    end

endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Self-checking bench for irq_pending_ctrl: directed scenarios with fixed
// expectations, then randomised traffic compared every cycle against an
// event-level reference model.

module tb_irq_pending_ctrl;

    localparam int unsigned N     = 8;
    localparam int unsigned IW    = 3;
    localparam logic [7:0]  EDGE  = 8'hFB;   // line 2 is level-sensitive

    logic          clk_i = 1'b0;
    logic          rst_ni;
    logic [N-1:0]  irq_i;
    logic          mask_we_i;
    logic [N-1:0]  mask_wdata_i;
    logic [N-1:0]  mask_o;
    logic [N-1:0]  pending_o;
    logic          irq_req_o;
    logic          ack_i;
    logic [IW-1:0] ack_id_i;
    logic          eoi_i;
    logic          active_o;
    logic [IW-1:0] active_id_o;
    logic          ack_err_o;

    int n_cmp = 0;
    int n_err = 0;

    irq_pending_ctrl #(.N_IRQ(N), .ID_W(IW), .EDGE_SEL(EDGE)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .irq_i        (irq_i),
        .mask_we_i    (mask_we_i),
        .mask_wdata_i (mask_wdata_i),
        .mask_o       (mask_o),
        .pending_o    (pending_o),
        .irq_req_o    (irq_req_o),
        .ack_i        (ack_i),
        .ack_id_i     (ack_id_i),
        .eoi_i        (eoi_i),
        .active_o     (active_o),
        .active_id_o  (active_id_o),
        .ack_err_o    (ack_err_o)
    );

    always #5 clk_i = ~clk_i;

    // ---------------- reference model ----------------
    typedef enum int {M_IDLE, M_REQ, M_ACTIVE} mstate_t;

    mstate_t      m_state;
    logic [7:0]   m_pend;
    logic [7:0]   m_mask;
    logic [2:0]   m_id;
    logic         m_err;
    logic [7:0]   m_samp[$];   // [0] newest sample of irq_i, [2] oldest

    task automatic model_reset();
        m_state = M_IDLE;
        m_pend  = '0;
        m_mask  = '0;
        m_id    = '0;
        m_err   = 1'b0;
        m_samp  = {8'h00, 8'h00, 8'h00};
    endtask

    task automatic model_step();
        logic [7:0] vis;
        logic [7:0] seen;
        logic [7:0] seen_before;
        logic       accepted;
        vis         = m_pend & m_mask;
        seen        = m_samp[1];
        seen_before = m_samp[2];
        accepted    = (m_state == M_REQ) && ack_i && vis[ack_id_i];
        m_err       = (m_state == M_REQ) && ack_i && !vis[ack_id_i];

        for (int i = 0; i < 8; i++) begin
            if (EDGE[i]) begin
                if (seen[i] && !seen_before[i])         m_pend[i] = 1'b1;
                else if (accepted && int'(ack_id_i) == i) m_pend[i] = 1'b0;
            end else begin
                m_pend[i] = seen[i];
            end
        end

        case (m_state)
            M_IDLE:   if (vis != 0) m_state = M_REQ;
            M_REQ: begin
                if (accepted) begin
                    m_state = M_ACTIVE;
                    m_id    = ack_id_i;
                end else if (vis == 0) begin
                    m_state = M_IDLE;
                end
            end
            default:  if (eoi_i) m_state = M_IDLE;
        endcase

        if (mask_we_i) m_mask = mask_wdata_i;
        m_samp.push_front(irq_i);
        void'(m_samp.pop_back());
    endtask

    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) model_reset();
        else         model_step();
    end

    // ---------------- checking ----------------
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic compare_model();
        check("mdl_pending", 32'(pending_o),   32'(m_pend & m_mask));
        check("mdl_req",     32'(irq_req_o),   32'(m_state == M_REQ));
        check("mdl_active",  32'(active_o),    32'(m_state == M_ACTIVE));
        check("mdl_id",      32'(active_id_o), 32'(m_id));
        check("mdl_err",     32'(ack_err_o),   32'(m_err));
        check("mdl_mask",    32'(mask_o),      32'(m_mask));
    endtask

    // Advance one clock edge and compare at the following falling edge
    task automatic tick();
        @(posedge clk_i);
        @(negedge clk_i);
        compare_model();
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic write_mask(input logic [7:0] m);
        mask_we_i    = 1'b1;
        mask_wdata_i = m;
        tick();
        mask_we_i    = 1'b0;
    endtask

    task automatic do_ack(input logic [2:0] id);
        ack_i    = 1'b1;
        ack_id_i = id;
        tick();
        ack_i    = 1'b0;
    endtask

    task automatic do_eoi();
        eoi_i = 1'b1;
        tick();
        eoi_i = 1'b0;
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [7:0] vis;
        int         start;
        int         pick;

        rst_ni       = 1'b0;
        irq_i        = '0;
        mask_we_i    = 1'b0;
        mask_wdata_i = '0;
        ack_i        = 1'b0;
        ack_id_i     = '0;
        eoi_i        = 1'b0;
        ticks(2);
        rst_ni = 1'b1;
        tick();
        check("rst_pending", 32'(pending_o), 32'h0);
        check("rst_req",     32'(irq_req_o), 32'h0);
        check("rst_mask",    32'(mask_o),    32'h0);

        // Edge latency on line 5
        write_mask(8'hFF);
        check("mask_ff", 32'(mask_o), 32'hFF);
        irq_i = 8'h20;                 // before edge k
        tick();                        // k
        tick();                        // k+1
        check("lat_k1_pending", 32'(pending_o), 32'h00);
        tick();                        // k+2
        check("lat_k2_pending", 32'(pending_o), 32'h20);
        check("lat_k2_req",     32'(irq_req_o), 32'h0);
        tick();                        // k+3
        check("lat_k3_req",     32'(irq_req_o), 32'h1);

        do_ack(3'd5);
        check("ack5_active",  32'(active_o),    32'h1);
        check("ack5_id",      32'(active_id_o), 32'h5);
        check("ack5_pending", 32'(pending_o),   32'h00);
        do_eoi();
        check("eoi_active", 32'(active_o), 32'h0);
        ticks(3);
        check("eoi_no_rereq", 32'(irq_req_o), 32'h0);

        // Bad ack while line 0 is pending
        irq_i = 8'h21;
        ticks(4);
        check("bad_pre_pending", 32'(pending_o), 32'h01);
        check("bad_pre_req",     32'(irq_req_o), 32'h1);
        do_ack(3'd3);
        check("bad_err",     32'(ack_err_o), 32'h1);
        check("bad_req",     32'(irq_req_o), 32'h1);
        check("bad_pending", 32'(pending_o), 32'h01);
        tick();
        check("bad_err_once", 32'(ack_err_o), 32'h0);

        // Reset while a handler is in service
        do_ack(3'd0);
        check("pre_rst_active", 32'(active_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        check("rst_async_active", 32'(active_o),    32'h0);
        check("rst_async_id",     32'(active_id_o), 32'h0);
        check("rst_async_mask",   32'(mask_o),      32'h0);
        check("rst_async_pend",   32'(pending_o),   32'h0);
        @(negedge clk_i);
        tick();
        rst_ni = 1'b1;
        tick();
        check("post_rst_req",    32'(irq_req_o), 32'h0);
        check("post_rst_active", 32'(active_o),  32'h0);

        // Masked edge on line 1, then unmask
        irq_i = 8'h02;
        ticks(5);
        check("masked_req", 32'(irq_req_o), 32'h0);
        mask_we_i    = 1'b1;           // sampled at edge m
        mask_wdata_i = 8'h02;
        tick();
        mask_we_i    = 1'b0;
        check("unmask_m_pending", 32'(pending_o), 32'h02);
        check("unmask_m_req",     32'(irq_req_o), 32'h0);
        tick();
        check("unmask_m1_req",    32'(irq_req_o), 32'h1);

        // New edge on line 1 coinciding with its ack: set wins
        irq_i = 8'h00;
        ticks(3);
        irq_i = 8'h02;                 // rise seen at the third edge from here
        ticks(2);
        do_ack(3'd1);
        check("simul_active",  32'(active_o),  32'h1);
        check("simul_pending", 32'(pending_o), 32'h02);
        do_eoi();
        check("handoff_idle", 32'(irq_req_o), 32'h0);
        tick();
        check("handoff_req",  32'(irq_req_o), 32'h1);

        // Randomised traffic against the model
        write_mask(8'hFF);
        for (int cyc = 0; cyc < 3000; cyc++) begin
            for (int b = 0; b < 8; b++)
                if ($urandom_range(0, 5) == 0) irq_i[b] = ~irq_i[b];

            if ($urandom_range(0, 39) == 0) begin
                mask_we_i    = 1'b1;
                mask_wdata_i = 8'($urandom) | 8'($urandom);
            end

            vis = m_pend & m_mask;
            if (m_state == M_REQ && $urandom_range(0, 2) == 0) begin
                ack_i    = 1'b1;
                ack_id_i = 3'($urandom);
                if (vis != 0 && $urandom_range(0, 3) != 0) begin
                    start = int'($urandom_range(0, 7));
                    pick  = -1;
                    for (int j = 0; j < 8; j++)
                        if (pick < 0 && vis[(start + j) % 8]) pick = (start + j) % 8;
                    ack_id_i = 3'(pick);
                end
            end else if ($urandom_range(0, 19) == 0) begin
                ack_i    = 1'b1;
                ack_id_i = 3'($urandom);
            end

            if (m_state == M_ACTIVE && $urandom_range(0, 3) == 0) eoi_i = 1'b1;
            else if ($urandom_range(0, 19) == 0)                  eoi_i = 1'b1;

            if ($urandom_range(0, 599) == 0) begin
                rst_ni = 1'b0;
                tick();
                rst_ni = 1'b1;
                mask_we_i    = 1'b1;
                mask_wdata_i = 8'($urandom) | 8'h0F;
            end

            tick();
            mask_we_i = 1'b0;
            ack_i     = 1'b0;
            eoi_i     = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
